// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a single-clock FIFO one byte at a time
// and sends each byte as an 8N1 UART frame on tx.
module fifo_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       empty,
  input  logic [7:0] po_data,
  output logic       rd_req,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SEND
  } state_t;

  state_t      r_state;
  logic        r_rd_req;
  logic        r_tx;
  logic [15:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_rd_req   <= 1'b0;
      r_tx       <= 1'b1;
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd_req <= !empty;
          if (!empty)
            r_state <= S_READ;
        end
        S_READ: begin
          r_rd_req <= 1'b0;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          r_shift    <= po_data;
          r_tx       <= 1'b0;
          r_baud_cnt <= 16'd0;
          r_bit_cnt  <= 4'd0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= 16'd0;
            if (r_bit_cnt == 4'd9) begin
              r_bit_cnt <= 4'd0;
              r_tx      <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              // ones shifted in behind the data become the stop bit
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b1, r_shift[7:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_req = r_rd_req;
  assign tx     = r_tx;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer for the 8-bit single-clock FIFO. It drains the FIFO one byte at a time and transmits each byte as an 8N1 UART frame on `tx`. It issues exactly one single-cycle `rd_req` per byte and never reads while `empty` is high. It shares `sys_clk` and `sys_rst_n` with the FIFO. The FIFO runs in normal, non-show-ahead mode.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: `sys_clk` frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `BAUD_CNT_MAX` (localparam) = CLK_FREQ/BAUD, integer-truncated: clocks per bit, 5208 at defaults.
  - Must satisfy 2 ≤ BAUD_CNT_MAX ≤ 65535.

Ports:
- `sys_clk`  in  1: system clock, rising edge.
- `sys_rst_n`  in  1: reset, asynchronous, active-low.
- `empty`  in  1: FIFO empty flag.
- `po_data`  in  8: FIFO read data. Valid the cycle after the FIFO samples `rd_req` high.
- `rd_req`  out  1: FIFO read request. Registered, one-cycle pulse per byte.
- `tx`  out  1: serial output. Idle high.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Reset values: `rd_req`=0, `tx`=1, `busy`=0, state=IDLE, all counters 0, shift register 0.
- States: IDLE → READ → LOAD → SEND → IDLE.
- IDLE:
  - `empty`=0 at an edge → go to READ, `rd_req`<=1.
  - `empty`=1 → stay in IDLE, `rd_req`<=0.
  - `empty` is sampled only in IDLE.
- READ: lasts one cycle. `rd_req`<=0, go to LOAD. The FIFO sees `rd_req` high at this edge.
- LOAD: lasts one cycle.
  - At the next edge, capture `po_data` into an 8-bit shift register.
  - `tx`<=0 (start bit), clear the baud and bit counters, go to SEND.
- SEND:
  - 16-bit baud counter counts 0..BAUD_CNT_MAX-1 and wraps to 0.
  - 4-bit bit counter counts 0..9 and advances on each baud wrap.
  - At wrap, `tx` takes the next bit: bits 1–8 are data LSB first, bit 9 is the stop bit (1).
  - When the bit counter is 9 and the baud counter wraps, go to IDLE with `tx`=1.
- `busy`: combinational from the state register, `busy` = (state ≠ IDLE).
- Only one read is ever outstanding. No `rd_req` is issued in READ, LOAD or SEND, whatever `empty` does.
- Reset mid-operation: `tx` goes to 1 and `busy`/`rd_req` go to 0 immediately (asynchronously). The in-flight byte is discarded and not re-read.
  - After release, the next frame is full length with a fresh start bit.

## Timing
- Let edge k be the IDLE edge where `empty`=0 is sampled.
  - `rd_req` is high from k to k+1 (exactly 1 clock).
  - `tx` falls at edge k+2.
- Each bit lasts exactly BAUD_CNT_MAX clocks. A frame is 10·BAUD_CNT_MAX clocks.
- The last stop-bit clock is edge k+2+10·BAUD_CNT_MAX, which returns the block to IDLE.
- Back-to-back bytes (`empty` held low):
  - `rd_req` period is 10·BAUD_CNT_MAX + 3 clocks.
  - `tx` stays high for 3 extra clocks between frames, i.e. the stop bit is effectively BAUD_CNT_MAX+3 clocks.
- If `empty` rises during SEND, the current frame completes normally and no further `rd_req` is issued.
- If `empty` falls during SEND, it is acted on at the first IDLE edge.

## Test plan
Sim parameters: CLK_FREQ=50_000_000, BAUD=5_000_000, giving BAUD_CNT_MAX=10.
- Reset with `empty`=1 held for 1000 clocks → `tx`=1, `rd_req`=0, `busy`=0 throughout.
- FIFO holds a single byte 0xA5; `empty` falls:
  - `rd_req` is one 1-clock pulse at k.
  - From k+2, `tx` = 0,1,0,1,0,0,1,0,1,1, each bit held 10 clocks.
  - `busy` falls at k+102.
  - No second `rd_req`.
- FIFO preloaded with 0x00..0x03 → exactly 4 `rd_req` pulses spaced 103 clocks apart; decoded bytes are 0x00,0x01,0x02,0x03 in order; `empty`=1 afterwards, so the block idles.
- Assert `sys_rst_n`=0 during data bit 4, release after 5 clocks with the FIFO non-empty:
  - `tx`=1 and `busy`=0 immediately on reset.
  - After release, the next byte is sent as a complete 100-clock frame with a valid start bit.
- `empty` toggles high mid-frame and low again during the stop bit → the frame is unaffected; the next `rd_req` occurs 1 clock after the block returns to IDLE.
- Integrate with the FIFO write pattern (one write every 4 clocks, data incrementing 0..255 with wrap to 0) → the serial byte stream equals the written sequence, including the 0xFF→0x00 wrap; the FIFO never reports read-while-empty.
